// File: rtl/ras_ckpt_queue_if.sv
// Port bundle for the RAS checkpoint queue: allocate, commit, restore, flush,
// the registered RAS update port and occupancy status.
interface ras_ckpt_queue_if #(
    parameter int RAS_INDEX_WIDTH = 3,
    parameter int CKPT_TAG_WIDTH  = 3
);
    // Allocation is the only handshake: a checkpoint is taken on a cycle where
    // enq_valid and enq_ready are both high; enq_tag names it on that cycle.
    // commit/restore/flush are single-cycle commands with no back-pressure.
    logic                       enq_valid;
    logic [RAS_INDEX_WIDTH-1:0] enq_ras_index;
    logic                       enq_ready;
    logic [CKPT_TAG_WIDTH-1:0]  enq_tag;
    logic                       commit_valid;
    logic                       restore_valid;
    logic [CKPT_TAG_WIDTH-1:0]  restore_tag;
    logic                       flush_valid;
    logic [RAS_INDEX_WIDTH-1:0] flush_ras_index;
    logic                       update0_valid;
    logic [RAS_INDEX_WIDTH-1:0] update0_ras_index;
    logic [CKPT_TAG_WIDTH:0]    count;
    logic                       empty;
    logic                       full;

    modport master (
        output enq_valid, enq_ras_index, commit_valid, restore_valid,
               restore_tag, flush_valid, flush_ras_index,
        input  enq_ready, enq_tag, update0_valid, update0_ras_index,
               count, empty, full
    );

    modport slave (
        input  enq_valid, enq_ras_index, commit_valid, restore_valid,
               restore_tag, flush_valid, flush_ras_index,
        output enq_ready, enq_tag, update0_valid, update0_ras_index,
               count, empty, full
    );
endinterface

// File: rtl/ras_ckpt_queue.sv
// In-order queue of RAS stack-pointer checkpoints; rolls the RAS back on a
// mispredict (restore) or a full pipeline flush via a registered update pulse.
module ras_ckpt_queue #(
    parameter int RAS_INDEX_WIDTH = 3,
    parameter int CKPT_ENTRIES    = 8,
    parameter int CKPT_TAG_WIDTH  = $clog2(CKPT_ENTRIES)
) (
    input logic            CLK,
    input logic            RST,
    ras_ckpt_queue_if.slave bus
);
    localparam int PTR_WIDTH = CKPT_TAG_WIDTH + 1;
    localparam logic [PTR_WIDTH-1:0] FULL_COUNT = PTR_WIDTH'(CKPT_ENTRIES);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);

    logic [PTR_WIDTH-1:0]       head_q, tail_q;
    logic [PTR_WIDTH-1:0]       head_d, tail_d;
    logic [PTR_WIDTH-1:0]       count_w;
    logic [RAS_INDEX_WIDTH-1:0] entry_q [CKPT_ENTRIES];

    logic [CKPT_TAG_WIDTH-1:0]  head_tag, tail_tag, restore_off;
    logic                       empty_w, full_w, enq_ready_w;
    logic                       enq_fire, commit_fire, restore_fire;

    logic                       update_valid_q, update_valid_d;
    logic [RAS_INDEX_WIDTH-1:0] update_index_q, update_index_d;

    // Pointers carry a wrap bit so full and empty are distinguishable.
    assign head_tag    = head_q[CKPT_TAG_WIDTH-1:0];
    assign tail_tag    = tail_q[CKPT_TAG_WIDTH-1:0];
    assign count_w     = tail_q - head_q;
    assign empty_w     = (count_w == '0);
    assign full_w      = (count_w == FULL_COUNT);

    assign enq_ready_w  = ~full_w & ~bus.restore_valid & ~bus.flush_valid;
    assign enq_fire     = bus.enq_valid & enq_ready_w;
    assign commit_fire  = bus.commit_valid & ~empty_w & ~bus.flush_valid;
    assign restore_fire = bus.restore_valid & ~bus.flush_valid;
    assign restore_off  = bus.restore_tag - head_tag;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (bus.flush_valid) begin
            tail_d = head_q;
        end else begin
            if (commit_fire) begin
                head_d = head_q + PTR_ONE;
            end
            // Truncation is measured from the pre-commit head so the tagged
            // entry survives; a same-cycle commit may then retire it.
            if (restore_fire) begin
                tail_d = head_q + {1'b0, restore_off} + PTR_ONE;
            end else if (enq_fire) begin
                tail_d = tail_q + PTR_ONE;
            end
        end
    end

    always_comb begin
        update_valid_d = bus.flush_valid | bus.restore_valid;
        update_index_d = update_index_q;
        if (bus.flush_valid) begin
            update_index_d = bus.flush_ras_index;
        end else if (bus.restore_valid) begin
            update_index_d = entry_q[bus.restore_tag];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            head_q         <= '0;
            tail_q         <= '0;
            update_valid_q <= 1'b0;
            update_index_q <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            update_valid_q <= update_valid_d;
            update_index_q <= update_index_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < CKPT_ENTRIES; i++) begin
                entry_q[i] <= '0;
            end
        end else if (enq_fire) begin
            entry_q[tail_tag] <= bus.enq_ras_index;
        end
    end

    assign bus.enq_ready         = enq_ready_w;
    assign bus.enq_tag           = tail_tag;
    assign bus.count             = count_w;
    assign bus.empty             = empty_w;
    assign bus.full              = full_w;
    assign bus.update0_valid     = update_valid_q;
    assign bus.update0_ras_index = update_index_q;
endmodule
